keypad4x4_scanner: RTL and testbench
====================================

# keypad4x4_scanner

Scans a 4x4 matrix keypad by driving one column low at a time and reading the four rows. It debounces the result over whole scan frames and reports each new single-key press as a 4-bit code with a one-cycle strobe. It is the input-side counterpart of the multiplexed 7-segment display driver: both share the same active-low column/digit drive pattern and the same board clock. Its outputs feed the digit registers that the display driver shows.

## Interface
- SCAN_DIV, 50000: ck cycles per column step (50 MHz → 1 kHz step); legal range 4..2^20.
- DEBOUNCE, 4: consecutive identical frames needed to accept a press or a release; legal range 2..15.
- ck  input  1  system clock, all logic on rising edge.
- R  input  1  reset, asynchronous, active-low.
- Row  input  4  keypad rows, active-low (externally pulled up), asynchronous to ck.
- Col  output  4  column drive, active-low, exactly one bit low.
- Key  output  4  code of last accepted key = {row_index[1:0], col_index[1:0]}.
- Valid  output  1  one-cycle strobe, new Key accepted.
- Pressed  output  1  level, high while the accepted key is considered held.

## Operation
- Row passes through a 2-flop synchronizer before use.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1).
- col_sel is 2 bits and increments on tick, wrapping 3→0. Col mapping: 0→1110, 1→1101, 2→1011, 3→0111.
- On tick, the synchronized Row is sampled for the current col_sel before it advances. Settling time is therefore SCAN_DIV-2 cycles.
- Frame accumulators:
  - hits: count of zero row bits, saturating at 2.
  - code: {row_index, col_sel} of the last zero bit found; for multiple zero bits in one column, the lowest row index wins, but hits ≥ 2 anyway.
  - The tick at col_sel==0 overwrites the accumulators; ticks at 1..3 accumulate.
- frame_done is registered and is high for the one cycle after the tick at col_sel==3.
- Frame result classification: NONE (hits=0), SINGLE(code) (hits=1), MULTI (hits=2).
- FSM, updated only in the frame_done cycle. cnt is 4 bits, cand is 4 bits.
  - IDLE:
    - SINGLE(c) → CAND, cand=c, cnt=1.
    - Otherwise stay.
  - CAND:
    - SINGLE(cand) → cnt+1. If cnt+1==DEBOUNCE → HELD, Key=cand, Valid=1, Pressed=1.
    - SINGLE(other) → cand=other, cnt=1.
    - NONE or MULTI → IDLE.
  - HELD:
    - NONE → REL, cnt=1.
    - SINGLE or MULTI (any code) → stay; no re-trigger, Key unchanged.
  - REL:
    - NONE → cnt+1. If cnt+1==DEBOUNCE → IDLE, Pressed=0.
    - SINGLE or MULTI → HELD, Pressed stays 1, no Valid.
- Key holds its value until the next accepted press, including after release.
- Valid is high for exactly one cycle per accepted press. It is never asserted on release.

## Timing
- Reset (R low, asynchronous), all values immediate:
  - prescaler=0, col_sel=0, Col=1110.
  - Synchronizer flops = 1111, accumulators cleared, frame_done=0.
  - FSM=IDLE, cnt=0, cand=0.
  - Key=0000, Valid=0, Pressed=0.
- R deasserting mid-frame or mid-debounce restarts scanning from column 0. Partial frames are discarded.
- Frame length is 4*SCAN_DIV cycles.
- Cycle t is the tick at col_sel==3:
  - frame_done is high in t+1.
  - Key, Valid and Pressed change on the edge ending t+1, so they are visible in t+2.
- Press latency: a press that is stable across DEBOUNCE whole frames is accepted at the end of the DEBOUNCE-th frame. Worst case is DEBOUNCE+1 frames plus 4 cycles, because a press arriving mid-frame makes that frame non-SINGLE or a different SINGLE.
- Release latency: DEBOUNCE frames of NONE after the last frame that saw the key.
- A Row change inside a column step is seen only if it is still present at that column's tick.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
- Reset and idle: hold R low, then release with Row=1111 → Col cycles 1110,1101,1011,0111, each for 4 cycles; Key=0, Valid and Pressed never assert over 10 frames.
- Clean press: model key row 2 / col 1 (Row bit2 low while Col=1101), held 6 frames → exactly one Valid pulse at the end of the 3rd full frame; Key=1001; Pressed=1 until 3 NONE frames after release, then 0.
- Bounce rejection: toggle the key at a 1-frame period for 8 frames, then hold → no Valid during toggling; one Valid after 3 stable frames.
- Two keys: keys 0000 and 1111 held together for 6 frames → no Valid, FSM stays IDLE. While key 0101 is HELD, add a second key → no Valid; Key stays 0101.
- Release glitch: while HELD, release for 2 frames, then press again → Pressed stays 1, no second Valid. Releasing for 3 frames then pressing 0011 for 3 frames → Pressed falls, then Valid with Key=0011.
- Reset mid-debounce: assert R after 2 qualifying frames → all outputs return to reset values immediately; after release, 3 fresh frames are needed before Valid.

Source files
------------

// File: rtl/keypad4x4_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, gathers a
// per-frame row summary, and debounces single-key presses over whole frames.
module keypad4x4_scanner #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       ck,
    input  logic       R,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] Key,
    output logic       Valid,
    output logic       Pressed
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAND = 2'd1,
        S_HELD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    col_sel_q;
    logic [3:0]    col_q;
    logic          tick;

    logic [1:0]    hits_q, hits_d;
    logic [3:0]    code_q, code_d;
    logic          frame_done_q;

    logic [2:0]    zeros;
    logic [2:0]    hit_sum;
    logic [1:0]    row_idx;
    logic          found;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          pressed_q, pressed_d;

    logic          res_none, res_single;
    logic [CW-1:0] cnt_inc;
    logic          cnt_full;

    assign tick = (presc_q == PW'(SCAN_DIV - 1));

    // Row synchronizer, prescaler and column walker
    always_ff @(posedge ck or negedge R) begin
        if (!R) begin
            row_s1_q     <= 4'b1111;
            row_s2_q     <= 4'b1111;
            presc_q      <= '0;
            col_sel_q    <= 2'd0;
            col_q        <= 4'b1110;
            hits_q       <= 2'd0;
            code_q       <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            row_s1_q     <= Row;
            row_s2_q     <= row_s1_q;
            presc_q      <= tick ? '0 : presc_q + PW'(1);
            frame_done_q <= tick && (col_sel_q == 2'd3);
            if (tick) begin
                col_sel_q <= col_sel_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                hits_q    <= hits_d;
                code_q    <= code_d;
            end
        end
    end

    // Column summary; scanning downward leaves the lowest zero row as the winner
    always_comb begin
        zeros   = 3'd0;
        row_idx = 2'd0;
        found   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s2_q[i]) begin
                zeros   = zeros + 3'd1;
                row_idx = 2'(i);
                found   = 1'b1;
            end
        end
        hit_sum = ((col_sel_q == 2'd0) ? 3'd0 : {1'b0, hits_q}) + zeros;
        hits_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        if (found) begin
            code_d = {row_idx, col_sel_q};
        end else begin
            code_d = (col_sel_q == 2'd0) ? 4'd0 : code_q;
        end
    end

    assign res_none   = (hits_q == 2'd0);
    assign res_single = (hits_q == 2'd1);
    assign cnt_inc    = cnt_q + CW'(1);
    assign cnt_full   = (cnt_inc == CW'(DEBOUNCE));

    always_ff @(posedge ck or negedge R) begin
        if (!R) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cand_q    <= 4'd0;
            key_q     <= 4'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    // Debounce state advances only once per completed frame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        if (frame_done_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (res_single) begin
                        state_d = S_CAND;
                        cand_d  = code_q;
                        cnt_d   = CW'(1);
                    end
                end
                S_CAND: begin
                    if (res_single && (code_q == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_full) state_d = S_HELD;
                    end else if (res_single) begin
                        cand_d = code_q;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (res_none) begin
                        state_d = S_REL;
                        cnt_d   = CW'(1);
                    end
                end
                S_REL: begin
                    if (res_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_full) state_d = S_IDLE;
                    end else begin
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        key_d     = key_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        if (frame_done_q) begin
            if ((state_q == S_CAND) && res_single && (code_q == cand_q) && cnt_full) begin
                key_d     = cand_q;
                valid_d   = 1'b1;
                pressed_d = 1'b1;
            end
            if ((state_q == S_REL) && res_none && cnt_full) begin
                pressed_d = 1'b0;
            end
        end
    end

    assign Col     = col_q;
    assign Key     = key_q;
    assign Valid   = valid_q;
    assign Pressed = pressed_q;

endmodule

// File: tb/tb_keypad4x4_scanner.sv
// Bench for keypad4x4_scanner: an ideal keypad drives Row from Col, and a
// frame-level debounce model predicts Col/Key/Valid/Pressed every cycle.
module tb_keypad4x4_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned FRAME = 4 * SD;

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K10 = 16'h0400;
    localparam logic [15:0] K15 = 16'h8000;

    typedef struct {
        int         kind;   // 0 none, 1 single, 2 multi
        logic [3:0] code;
    } fres_t;

    logic       ck = 1'b0;
    logic       R  = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       valid;
    logic       pressed;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int vcount = 0;
    int edges  = 0;
    bit armed  = 1'b0;

    fres_t      fq[$];
    fres_t      hq[$];
    logic [3:0] exp_key = 4'd0;
    logic       exp_pr  = 1'b0;

    always #5 ck = ~ck;

    keypad4x4_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .ck      (ck),
        .R       (R),
        .Row     (row),
        .Col     (col),
        .Key     (key),
        .Valid   (valid),
        .Pressed (pressed)
    );

    // Ideal switch matrix: a held key pulls its row low while its column is driven
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys[r*4 + c]) row[r] = 1'b0;
    end

    always @(posedge ck or negedge R) begin
        if (!R) edges <= 0;
        else    edges <= edges + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic fres_t classify(input logic [15:0] k);
        fres_t r;
        int n;
        n = 0;
        r.code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                r.code = 4'(i);
            end
        end
        r.kind = (n > 2) ? 2 : n;
        return r;
    endfunction

    // Per-cycle compare against the frame-level model
    always @(negedge ck) begin
        fres_t      r;
        logic [3:0] ecol;
        logic       ev;
        bit         all_single, all_none;
        if (armed) begin
            ev = 1'b0;
            if (!R) begin
                fq.delete();
                hq.delete();
                exp_key = 4'd0;
                exp_pr  = 1'b0;
                chk("rst_col", 32'(col), 32'(4'b1110));
                chk("rst_key", 32'(key), 32'd0);
                chk("rst_valid", 32'(valid), 32'd0);
                chk("rst_pressed", 32'(pressed), 32'd0);
            end else begin
                ecol = ~(4'b0001 << ((edges / SD) % 4));
                if (edges % FRAME == 8) fq.push_back(classify(keys));
                if (edges >= FRAME + 1 && (edges - FRAME - 1) % FRAME == 0) begin
                    if (fq.size() == 0) begin
                        chk("frame_queue_empty", 32'd1, 32'd0);
                    end else begin
                        r = fq.pop_front();
                        hq.push_back(r);
                        if (hq.size() > DB) void'(hq.pop_front());
                        if (hq.size() == DB) begin
                            all_single = 1'b1;
                            all_none   = 1'b1;
                            foreach (hq[i]) begin
                                if (hq[i].kind != 1 || hq[i].code != hq[0].code) all_single = 1'b0;
                                if (hq[i].kind != 0) all_none = 1'b0;
                            end
                            if (!exp_pr && all_single) begin
                                exp_pr  = 1'b1;
                                exp_key = hq[0].code;
                                ev      = 1'b1;
                            end else if (exp_pr && all_none) begin
                                exp_pr = 1'b0;
                            end
                        end
                    end
                end
                chk("col", 32'(col), 32'(ecol));
                chk("key", 32'(key), 32'(exp_key));
                chk("valid", 32'(valid), 32'(ev));
                chk("pressed", 32'(pressed), 32'(exp_pr));
                if (valid) vcount++;
            end
        end
    end

    task automatic frames(input int n, input logic [15:0] ks);
        keys = ks;
        repeat (n * FRAME) @(posedge ck);
        #2;
    endtask

    // One frame of ks, pinning DUT and model to literals once the previous frame has landed
    task automatic frame_pin(input logic [15:0] ks, input logic [3:0] ek, input logic ep, input int evc);
        keys = ks;
        repeat (2) @(posedge ck);
        #2;
        chk("pin_key", 32'(key), 32'(ek));
        chk("pin_pressed", 32'(pressed), 32'(ep));
        chk("pin_vcount", 32'(vcount), 32'(evc));
        chk("pin_model_key", 32'(exp_key), 32'(ek));
        chk("pin_model_pressed", 32'(exp_pr), 32'(ep));
        repeat (FRAME - 2) @(posedge ck);
        #2;
    endtask

    task automatic do_reset();
        R = 1'b0;
        #1;
        chk("rst_now_col", 32'(col), 32'(4'b1110));
        chk("rst_now_key", 32'(key), 32'd0);
        chk("rst_now_valid", 32'(valid), 32'd0);
        chk("rst_now_pressed", 32'(pressed), 32'd0);
        repeat (3) @(posedge ck);
        #2;
        R = 1'b1;
    endtask

    initial begin
        keys = 16'h0000;
        #1;
        R = 1'b0;
        armed = 1'b1;
        @(posedge ck);
        #2;
        do_reset();

        // Reset and idle
        frames(10, 16'h0000);
        frame_pin(16'h0000, 4'b0000, 1'b0, 0);

        // Clean press of row 2 / col 1, then release
        frames(2, K9);
        frame_pin(K9, 4'b0000, 1'b0, 0);
        frame_pin(K9, 4'b1001, 1'b1, 1);
        frames(2, K9);
        frames(2, 16'h0000);
        frame_pin(16'h0000, 4'b1001, 1'b1, 1);
        frame_pin(16'h0000, 4'b1001, 1'b0, 1);

        // Bounce rejection, then a stable hold
        for (int i = 0; i < 4; i++) begin
            frames(1, K6);
            frames(1, 16'h0000);
        end
        frames(2, K6);
        frame_pin(K6, 4'b1001, 1'b0, 1);
        frame_pin(K6, 4'b0110, 1'b1, 2);
        frames(1, K6);
        frames(4, 16'h0000);

        // Two keys together never qualify; a second key while held is ignored
        frames(5, K0 | K15);
        frame_pin(K0 | K15, 4'b0110, 1'b0, 2);
        frames(3, K5);
        frame_pin(K5, 4'b0101, 1'b1, 3);
        frames(2, K5 | K10);
        frame_pin(K5 | K10, 4'b0101, 1'b1, 3);
        frames(3, 16'h0000);
        frame_pin(16'h0000, 4'b0101, 1'b0, 3);

        // Release glitch, then a full release and a new key
        frames(3, K5);
        frame_pin(K5, 4'b0101, 1'b1, 4);
        frames(2, 16'h0000);
        frames(2, K5);
        frame_pin(K5, 4'b0101, 1'b1, 4);
        frames(2, 16'h0000);
        frame_pin(16'h0000, 4'b0101, 1'b1, 4);
        frame_pin(K3, 4'b0101, 1'b0, 4);
        frames(1, K3);
        frame_pin(K3, 4'b0101, 1'b0, 4);
        frame_pin(K3, 4'b0011, 1'b1, 5);
        frames(4, 16'h0000);

        // Reset mid-debounce discards the qualifying frames
        frames(2, K9);
        repeat (5) @(posedge ck);
        #2;
        do_reset();
        frames(2, K9);
        frame_pin(K9, 4'b0000, 1'b0, 5);
        frame_pin(K9, 4'b1001, 1'b1, 6);
        frames(1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
